// File: rtl/obj_det_pkg.sv
// Shared frame geometry, RGB444 field layout and FSM encoding for the
// object-detection frame evaluation stage.
package obj_det_pkg;

  localparam int FRAME_W    = 320;
  localparam int FRAME_H    = 240;
  localparam int FRAME_SIZE = FRAME_W * FRAME_H;
  localparam int PIXEL_W    = 12;
  localparam int ADDR_W     = 17;

  localparam int R_HI = 11;
  localparam int R_LO = 8;
  localparam int G_HI = 7;
  localparam int G_LO = 4;
  localparam int B_HI = 3;
  localparam int B_LO = 0;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } det_state_t;

  function automatic logic [3:0] abs_diff4(input logic [3:0] a, input logic [3:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/pix_abs_diff.sv
// Combinational RGB444 distance: |dR| + |dG| + |dB|, at most 45 so 6 bits suffice.
module pix_abs_diff
  import obj_det_pkg::*;
(
  input  logic [PIXEL_W-1:0] cur_pixel,
  input  logic [PIXEL_W-1:0] ref_pixel,
  output logic [5:0]         diff_sum
);

  logic [3:0] d_r, d_g, d_b;

  always_comb begin
    d_r      = abs_diff4(cur_pixel[R_HI:R_LO], ref_pixel[R_HI:R_LO]);
    d_g      = abs_diff4(cur_pixel[G_HI:G_LO], ref_pixel[G_HI:G_LO]);
    d_b      = abs_diff4(cur_pixel[B_HI:B_LO], ref_pixel[B_HI:B_LO]);
    diff_sum = {2'b00, d_r} + {2'b00, d_g} + {2'b00, d_b};
  end

endmodule

// File: rtl/obj_det_frame_eval.sv
// Per-pixel change detection against the reference frame, per-frame area and
// bounding-box accumulation, consecutive-detection counting and alert debounce.
module obj_det_frame_eval
  import obj_det_pkg::*;
#(
  parameter int PIX_THRESH   = 6,
  parameter int AREA_THRESH  = 400,
  parameter int ALERT_FRAMES = 30,
  parameter int CLEAR_FRAMES = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               det_enable,
  input  logic               frame_start,
  input  logic               pix_valid,
  input  logic [PIXEL_W-1:0] cur_pixel,
  input  logic [PIXEL_W-1:0] ref_pixel,
  output logic [9:0]         frame_count,
  output logic [16:0]        changed_count,
  output logic [8:0]         bbox_xmin,
  output logic [8:0]         bbox_xmax,
  output logic [7:0]         bbox_ymin,
  output logic [7:0]         bbox_ymax,
  output logic               bbox_valid,
  output logic               frame_done,
  output logic               alert
);

  localparam int X_W   = 9;
  localparam int Y_W   = 8;
  localparam int CNT_W = ADDR_W;
  localparam int FC_W  = 10;
  localparam int Q_W   = 8;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [FC_W-1:0]  FC_MAX  = '1;
  localparam logic [Q_W-1:0]   Q_MAX   = '1;

  det_state_t state, next_state;
  logic       open_frame, close_frame, pipe_en;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (!det_enable)                        next_state = IDLE;
    else if (state == IDLE && frame_start)  next_state = ACCUM;
  end

  // A frame_start from IDLE only opens a frame; only one seen in ACCUM closes one.
  always_comb begin
    open_frame  = 1'b0;
    close_frame = 1'b0;
    pipe_en     = 1'b0;
    if (det_enable) begin
      open_frame = frame_start;
      pipe_en    = frame_start;
      if (state == ACCUM) begin
        close_frame = frame_start;
        pipe_en     = 1'b1;
      end
    end
  end

  logic [X_W-1:0] x_cnt, x_use;
  logic [Y_W-1:0] y_cnt, y_use;

  always_comb begin
    x_use = open_frame ? '0 : x_cnt;
    y_use = open_frame ? '0 : y_cnt;
  end

  // y saturates on the last line so oversized frames keep being compared.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_cnt <= '0;
      y_cnt <= '0;
    end else if (!det_enable) begin
      x_cnt <= '0;
      y_cnt <= '0;
    end else if (pipe_en && pix_valid) begin
      if (x_use == X_W'(FRAME_W - 1)) begin
        x_cnt <= '0;
        y_cnt <= (y_use == Y_W'(FRAME_H - 1)) ? y_use : y_use + Y_W'(1);
      end else begin
        x_cnt <= x_use + X_W'(1);
        y_cnt <= y_use;
      end
    end else if (open_frame) begin
      x_cnt <= '0;
      y_cnt <= '0;
    end
  end

  logic               s0_valid;
  logic [PIXEL_W-1:0] s0_cur;
  logic [X_W-1:0]     s0_x;
  logic [Y_W-1:0]     s0_y;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s0_valid <= 1'b0;
      s0_cur   <= '0;
      s0_x     <= '0;
      s0_y     <= '0;
    end else begin
      s0_valid <= pipe_en && pix_valid;
      s0_cur   <= cur_pixel;
      s0_x     <= x_use;
      s0_y     <= y_use;
    end
  end

  // The BRAM read data for the S0 pixel arrives on ref_pixel this cycle.
  logic [5:0]     diff_sum;
  logic           s1_valid, s1_changed;
  logic [X_W-1:0] s1_x;
  logic [Y_W-1:0] s1_y;

  pix_abs_diff u_pix_abs_diff (
    .cur_pixel (s0_cur),
    .ref_pixel (ref_pixel),
    .diff_sum  (diff_sum)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid   <= 1'b0;
      s1_changed <= 1'b0;
      s1_x       <= '0;
      s1_y       <= '0;
    end else begin
      s1_valid   <= s0_valid && det_enable;
      s1_changed <= diff_sum > 6'(PIX_THRESH);
      s1_x       <= s0_x;
      s1_y       <= s0_y;
    end
  end

  logic [CNT_W-1:0] acc_cnt, base_cnt, cnt_next;
  logic [X_W-1:0]   acc_xmin, acc_xmax, base_xmin, base_xmax, xmin_next, xmax_next;
  logic [Y_W-1:0]   acc_ymin, acc_ymax, base_ymin, base_ymax, ymin_next, ymax_next;
  logic             hit;

  // A pixel landing on the closing cycle updates the freshly cleared accumulators.
  always_comb begin
    if (close_frame || !det_enable) begin
      base_cnt  = '0;
      base_xmin = '1;
      base_xmax = '0;
      base_ymin = '1;
      base_ymax = '0;
    end else begin
      base_cnt  = acc_cnt;
      base_xmin = acc_xmin;
      base_xmax = acc_xmax;
      base_ymin = acc_ymin;
      base_ymax = acc_ymax;
    end
    hit       = s1_valid && s1_changed && det_enable;
    cnt_next  = base_cnt;
    xmin_next = base_xmin;
    xmax_next = base_xmax;
    ymin_next = base_ymin;
    ymax_next = base_ymax;
    if (hit) begin
      if (base_cnt != CNT_MAX) cnt_next = base_cnt + CNT_W'(1);
      if (s1_x < base_xmin)    xmin_next = s1_x;
      if (s1_x > base_xmax)    xmax_next = s1_x;
      if (s1_y < base_ymin)    ymin_next = s1_y;
      if (s1_y > base_ymax)    ymax_next = s1_y;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_cnt  <= '0;
      acc_xmin <= '1;
      acc_xmax <= '0;
      acc_ymin <= '1;
      acc_ymax <= '0;
    end else begin
      acc_cnt  <= cnt_next;
      acc_xmin <= xmin_next;
      acc_xmax <= xmax_next;
      acc_ymin <= ymin_next;
      acc_ymax <= ymax_next;
    end
  end

  logic           detected;
  logic [FC_W-1:0] fc_new;
  logic [Q_W-1:0]  quiet_cnt, quiet_new;

  always_comb begin
    detected  = acc_cnt >= CNT_W'(AREA_THRESH);
    fc_new    = '0;
    quiet_new = '0;
    if (detected) fc_new    = (frame_count == FC_MAX) ? frame_count : frame_count + FC_W'(1);
    else          quiet_new = (quiet_cnt == Q_MAX) ? quiet_cnt : quiet_cnt + Q_W'(1);
  end

  // Alert set wins over clear when both thresholds are met on the same close.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_count <= '0;
      quiet_cnt   <= '0;
      alert       <= 1'b0;
    end else if (!det_enable) begin
      frame_count <= '0;
      quiet_cnt   <= '0;
      alert       <= 1'b0;
    end else if (close_frame) begin
      frame_count <= fc_new;
      quiet_cnt   <= quiet_new;
      if (fc_new >= FC_W'(ALERT_FRAMES))       alert <= 1'b1;
      else if (quiet_new >= Q_W'(CLEAR_FRAMES)) alert <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      changed_count <= '0;
      bbox_xmin     <= '0;
      bbox_xmax     <= '0;
      bbox_ymin     <= '0;
      bbox_ymax     <= '0;
      bbox_valid    <= 1'b0;
      frame_done    <= 1'b0;
    end else begin
      frame_done <= close_frame;
      if (close_frame) begin
        changed_count <= acc_cnt;
        bbox_valid    <= acc_cnt != '0;
        bbox_xmin     <= (acc_cnt != '0) ? acc_xmin : '0;
        bbox_xmax     <= (acc_cnt != '0) ? acc_xmax : '0;
        bbox_ymin     <= (acc_cnt != '0) ? acc_ymin : '0;
        bbox_ymax     <= (acc_cnt != '0) ? acc_ymax : '0;
      end
    end
  end

endmodule

// File: tb/tb_obj_det_frame_eval.sv
// Frame-level bench: table of frame patterns with hand-derived results, a
// small frame_count/alert model, and a queue scoreboard popped on frame_done.
module tb_obj_det_frame_eval;

  localparam int W = 320;
  localparam int H = 240;
  localparam logic [11:0] BG = 12'h5A3;

  localparam int V_CLEAN  = 0;
  localparam int V_BLOCK  = 1;
  localparam int V_EQ6    = 2;
  localparam int V_GT6    = 3;
  localparam int V_WRAP   = 4;
  localparam int V_A399   = 5;
  localparam int V_DET    = 6;
  localparam int V_QUIET  = 7;
  localparam int V_SINGLE = 8;
  localparam int V_R500   = 9;

  typedef struct {
    int          npix;
    int          x0, x1, y0, y1;
    logic [11:0] cur_in, ref_in;
    int          exp_cnt, exp_xmin, exp_xmax, exp_ymin, exp_ymax;
    int          exp_valid;
  } frame_vec_t;

  typedef struct {
    int cnt, xmin, xmax, ymin, ymax, valid, fc, alert;
  } exp_t;

  logic        clk, reset, det_enable, frame_start, pix_valid;
  logic [11:0] cur_pixel, ref_pixel;
  logic [9:0]  frame_count;
  logic [16:0] changed_count;
  logic [8:0]  bbox_xmin, bbox_xmax;
  logic [7:0]  bbox_ymin, bbox_ymax;
  logic        bbox_valid, frame_done, alert;

  obj_det_frame_eval dut (
    .clk           (clk),
    .reset         (reset),
    .det_enable    (det_enable),
    .frame_start   (frame_start),
    .pix_valid     (pix_valid),
    .cur_pixel     (cur_pixel),
    .ref_pixel     (ref_pixel),
    .frame_count   (frame_count),
    .changed_count (changed_count),
    .bbox_xmin     (bbox_xmin),
    .bbox_xmax     (bbox_xmax),
    .bbox_ymin     (bbox_ymin),
    .bbox_ymax     (bbox_ymax),
    .bbox_valid    (bbox_valid),
    .frame_done    (frame_done),
    .alert         (alert)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  frame_vec_t  vecs [10];
  frame_vec_t  pend;
  exp_t        exp_q [$];
  exp_t        mon_e;
  logic [11:0] ref_pend;
  int          n_checks, n_pass;
  int          m_fc, m_quiet, m_alert;
  bit          in_accum;

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_checks++;
    if (actual == expected) n_pass++;
    else $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
  endtask

  task automatic applyStimulus(input logic fs, input logic v, input logic [11:0] cur, input logic [11:0] rf);
    frame_start = fs;
    pix_valid   = v;
    cur_pixel   = cur;
    ref_pixel   = ref_pend;
    ref_pend    = v ? rf : 12'h000;
    @(posedge clk);
    #1;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_frame_count"}, frame_count, 0);
    checkOutput({tag, "_changed_count"}, changed_count, 0);
    checkOutput({tag, "_bbox_xmin"}, bbox_xmin, 0);
    checkOutput({tag, "_bbox_xmax"}, bbox_xmax, 0);
    checkOutput({tag, "_bbox_ymin"}, bbox_ymin, 0);
    checkOutput({tag, "_bbox_ymax"}, bbox_ymax, 0);
    checkOutput({tag, "_bbox_valid"}, bbox_valid, 0);
    checkOutput({tag, "_frame_done"}, frame_done, 0);
    checkOutput({tag, "_alert"}, alert, 0);
  endtask

  // Closes the pending frame in the model; the caller drives the frame_start.
  task automatic closeModel();
    exp_t e;
    if (in_accum) begin
      if (pend.exp_cnt >= 400) begin
        m_fc    = (m_fc >= 1023) ? 1023 : m_fc + 1;
        m_quiet = 0;
      end else begin
        m_fc    = 0;
        m_quiet = m_quiet + 1;
      end
      if (m_fc >= 30)        m_alert = 1;
      else if (m_quiet >= 8) m_alert = 0;
      e.cnt  = pend.exp_cnt;  e.xmin = pend.exp_xmin; e.xmax = pend.exp_xmax;
      e.ymin = pend.exp_ymin; e.ymax = pend.exp_ymax; e.valid = pend.exp_valid;
      e.fc   = m_fc;          e.alert = m_alert;
      exp_q.push_back(e);
    end
    in_accum = 1'b1;
  endtask

  task automatic idleAndDrain();
    repeat (4) applyStimulus(1'b0, 1'b0, BG, BG);
    checkOutput("frame_done_drained", exp_q.size(), 0);
  endtask

  task automatic runFrame(input int k, input bit coincide);
    frame_vec_t v;
    int px, py;
    bit inblk;
    v = vecs[k];
    closeModel();
    if (!coincide) applyStimulus(1'b1, 1'b0, BG, BG);
    pend = v;
    for (int i = 0; i < v.npix; i++) begin
      px    = i % W;
      py    = (i / W > H - 1) ? H - 1 : i / W;
      inblk = px >= v.x0 && px <= v.x1 && py >= v.y0 && py <= v.y1;
      applyStimulus(coincide && i == 0, 1'b1, inblk ? v.cur_in : BG, inblk ? v.ref_in : BG);
    end
    idleAndDrain();
  endtask

  task automatic closeOnly();
    closeModel();
    applyStimulus(1'b1, 1'b0, BG, BG);
    idleAndDrain();
  endtask

  always @(negedge clk) begin
    if (!reset && frame_done) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_frame_done", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        checkOutput("changed_count", changed_count, mon_e.cnt);
        checkOutput("bbox_xmin", bbox_xmin, mon_e.xmin);
        checkOutput("bbox_xmax", bbox_xmax, mon_e.xmax);
        checkOutput("bbox_ymin", bbox_ymin, mon_e.ymin);
        checkOutput("bbox_ymax", bbox_ymax, mon_e.ymax);
        checkOutput("bbox_valid", bbox_valid, mon_e.valid);
        checkOutput("frame_count", frame_count, mon_e.fc);
        checkOutput("alert", alert, mon_e.alert);
      end
    end
  end

  initial begin
    #1_500_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[V_CLEAN]  = '{640,   1,   0,  0,  0, BG,     BG,     0,   0,   0,   0,  0,  0};
    vecs[V_BLOCK]  = '{22400, 100, 119, 50, 69, 12'hFFF, 12'h000, 400, 100, 119, 50, 69, 1};
    vecs[V_EQ6]    = '{640,   10,  29,  0,  1, 12'h444, 12'h222, 0,   0,   0,   0,  0,  0};
    vecs[V_GT6]    = '{640,   10,  29,  0,  1, 12'h445, 12'h222, 40,  10,  29,  0,  1,  1};
    vecs[V_WRAP]   = '{960,   318, 319, 0,  2, 12'h000, 12'h333, 6,   318, 319, 0,  2,  1};
    vecs[V_A399]   = '{960,   0,   132, 0,  2, 12'hFFF, 12'h000, 399, 0,   132, 0,  2,  1};
    vecs[V_DET]    = '{520,   0,   199, 0,  1, 12'hFFF, 12'h000, 400, 0,   199, 0,  1,  1};
    vecs[V_QUIET]  = '{16,    1,   0,   0,  0, BG,     BG,     0,   0,   0,   0,  0,  0};
    vecs[V_SINGLE] = '{16,    0,   0,   0,  0, 12'hFFF, 12'h000, 1,   0,   0,   0,  0,  1};
    vecs[V_R500]   = '{570,   0,   249, 0,  1, 12'hFFF, 12'h000, 500, 0,   249, 0,  1,  1};

    n_checks = 0; n_pass = 0;
    m_fc = 0; m_quiet = 0; m_alert = 0; in_accum = 1'b0;
    pend = vecs[V_CLEAN];
    ref_pend    = 12'h000;
    reset       = 1'b1;
    det_enable  = 1'b0;
    frame_start = 1'b0;
    pix_valid   = 1'b0;
    cur_pixel   = 12'h000;
    ref_pixel   = 12'h000;

    repeat (2) @(posedge clk);
    @(negedge clk);
    checkAllZero("reset");
    @(posedge clk);
    #1;
    reset      = 1'b0;
    det_enable = 1'b1;

    $display("[TB] table frames: clean, 20x20 block, threshold edges, wrap, area edge");
    for (int k = V_CLEAN; k <= V_A399; k++) runFrame(k, 1'b0);
    runFrame(V_QUIET, 1'b0);

    $display("[TB] alert debounce: 30 detected frames then clean frames");
    for (int i = 0; i < 30; i++) runFrame(V_DET, 1'b0);
    for (int i = 0; i < 9; i++)  runFrame(V_QUIET, 1'b0);

    $display("[TB] coincident frame_start and det_enable drop with alert high");
    for (int i = 0; i < 30; i++) runFrame(V_DET, 1'b0);
    runFrame(V_SINGLE, 1'b1);
    runFrame(V_QUIET, 1'b0);
    det_enable = 1'b0;
    applyStimulus(1'b0, 1'b0, BG, BG);
    @(negedge clk);
    checkOutput("drop_frame_count", frame_count, 0);
    checkOutput("drop_alert", alert, 0);
    checkOutput("drop_changed_count_held", changed_count, 1);
    checkOutput("drop_bbox_valid_held", bbox_valid, 1);
    m_fc = 0; m_quiet = 0; m_alert = 0; in_accum = 1'b0;
    @(posedge clk);
    #1;
    det_enable = 1'b1;
    runFrame(V_DET, 1'b0);
    runFrame(V_R500, 1'b0);

    $display("[TB] reset in the middle of an accumulating frame");
    reset = 1'b1;
    @(negedge clk);
    checkAllZero("reset_mid");
    @(posedge clk);
    #1;
    reset = 1'b0;
    m_fc = 0; m_quiet = 0; m_alert = 0; in_accum = 1'b0;
    runFrame(V_QUIET, 1'b0);
    closeOnly();
    checkOutput("final_queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
